// File: rtl/decode_sequencer.sv
// ---------------------------------------------------------------------------
// DecodeSequencer (module decode_sequencer)
//
// Multi-cycle micro-sequencer that sits beside the decode stage. It turns a
// CALL/INT into a series of return-address stack pushes and a RET/RTI into a
// series of pops, one DATA_W-wide stack word per cycle. After the words it
// flushes the younger instructions for FLUSH_CYCLES cycles and then returns to
// idle. ADDR_W must be a whole multiple of DATA_W.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   call_req_i     decoded CALL, held by decode until seq_accept_o
//   ret_req_i      decoded RET, held until seq_accept_o
//   rti_req_i      decoded RTI, held until seq_accept_o
//   int_req_i      external interrupt pulse, latched internally
//   hold_i         hazard-unit stall, freezes the sequencer
//   seq_accept_o   a request is consumed this cycle (combinational)
//   int_ack_o      the latched interrupt is taken this cycle (combinational)
//   stall_out_o    freeze fetch/decode while a sequence is in flight
//   push_o         push one stack word this cycle
//   pop_o          pop one stack word this cycle
//   word_idx_o     word being moved: PC word k (0 = least significant),
//                  PCW selects the flags word
//   is_int_o       current sequence is INT/RTI (selects the flags path)
//   flush_o        flush younger instructions
//   done_o         last cycle of the sequence
// ---------------------------------------------------------------------------
module decode_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int SAVE_FLAGS   = 1,
    parameter int FLUSH_CYCLES = 1,
    localparam int PCW = ADDR_W / DATA_W,
    localparam int NW  = PCW + SAVE_FLAGS,
    localparam int IW  = $clog2(NW + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          call_req_i,
    input  logic          ret_req_i,
    input  logic          rti_req_i,
    input  logic          int_req_i,
    input  logic          hold_i,
    output logic          seq_accept_o,
    output logic          int_ack_o,
    output logic          stall_out_o,
    output logic          push_o,
    output logic          pop_o,
    output logic [IW-1:0] word_idx_o,
    output logic          is_int_o,
    output logic          flush_o,
    output logic          done_o
);

    // One counter walks the stack words and is then reused for the flush
    // cycles, so it has to be wide enough for whichever phase is longer.
    localparam int MAXC = (NW > FLUSH_CYCLES) ? NW : FLUSH_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        POP,
        FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_int_q, is_int_d;
    logic            int_pend_q, int_pend_d;

    logic            intPending;
    logic [CW-1:0]   lastWord;
    logic [IW-1:0]   pushIdx;
    logic [IW-1:0]   popIdx;

    // State register. The interrupt latch keeps collecting pulses even while
    // hold is asserted, so it is updated every cycle outside reset; all other
    // state only moves when the next-state logic decides so.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_int_q   <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_int_q   <= is_int_d;
            int_pend_q <= int_pend_d;
        end
    end

    // Next-state and output logic. A pulse arriving this very cycle counts as
    // pending, so an interrupt can be acknowledged on the cycle it shows up.
    // Pushes go from the most significant PC word down to word 0 and finish
    // with the flags word; pops run in the exact reverse order so the stack
    // unwinds cleanly. While hold is high every action strobe is suppressed
    // and state/counter stay put, but the stall keeps following the state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_int_d     = is_int_q;
        seq_accept_o = 1'b0;
        int_ack_o    = 1'b0;
        push_o       = 1'b0;
        pop_o        = 1'b0;
        word_idx_o   = '0;
        flush_o      = 1'b0;
        done_o       = 1'b0;
        stall_out_o  = (state_q != IDLE);
        is_int_o     = is_int_q;

        intPending = int_pend_q | int_req_i;
        lastWord   = is_int_q ? CW'(NW - 1) : CW'(PCW - 1);

        if (int'(cnt_q) < PCW) begin
            pushIdx = IW'(PCW - 1 - int'(cnt_q));
        end else begin
            pushIdx = IW'(PCW);
        end

        if (is_int_q && (SAVE_FLAGS != 0)) begin
            popIdx = (cnt_q == '0) ? IW'(PCW) : IW'(int'(cnt_q) - 1);
        end else begin
            popIdx = IW'(int'(cnt_q));
        end

        case (state_q)
            IDLE: begin
                if (!hold_i && !rst_i) begin
                    cnt_d = '0;
                    if (intPending) begin
                        seq_accept_o = 1'b1;
                        int_ack_o    = 1'b1;
                        is_int_d     = 1'b1;
                        state_d      = PUSH;
                    end else if (call_req_i) begin
                        seq_accept_o = 1'b1;
                        is_int_d     = 1'b0;
                        state_d      = PUSH;
                    end else if (rti_req_i) begin
                        seq_accept_o = 1'b1;
                        is_int_d     = 1'b1;
                        state_d      = POP;
                    end else if (ret_req_i) begin
                        seq_accept_o = 1'b1;
                        is_int_d     = 1'b0;
                        state_d      = POP;
                    end
                end
            end
            PUSH, POP: begin
                if (!hold_i) begin
                    if (state_q == PUSH) begin
                        push_o     = 1'b1;
                        word_idx_o = pushIdx;
                    end else begin
                        pop_o      = 1'b1;
                        word_idx_o = popIdx;
                    end
                    if (cnt_q == lastWord) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                if (!hold_i) begin
                    flush_o = 1'b1;
                    if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                        done_o   = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                        is_int_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Repeat pulses merge into the one pending interrupt; only taking it
        // clears the latch.
        int_pend_d = intPending & ~int_ack_o;
    end

endmodule
